// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arb_types (package)
//  Description : State and grant types shared by the memory arbiter slice.
//  Revision    : 1.0
// ============================================================================
package mem_arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BUSY  = 2'd1,
        D_BUSY  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [0:0] {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } arb_grant_t;

    localparam int c_DEFAULT_ADDR_W = 32;
    localparam int c_DEFAULT_LINE_W = 256;

    // Round-robin: on a conflict the requester that did not win last time goes next.
    function automatic arb_grant_t rr_pick(input arb_grant_t last_grant);
        return (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Cache-side and memory-side line-port signals of the arbiter.
//  Revision    : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter view
    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // Caches + memory view
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one pmem line port between the
//                instruction cache (read) and data cache (read/write).
//  Revision    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_types::*;
#(
    parameter int ADDR_W = c_DEFAULT_ADDR_W,
    parameter int LINE_W = c_DEFAULT_LINE_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_grant_t        r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_is_write;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_pmem_read;
    logic w_pmem_write;
    logic w_i_resp;
    logic w_d_resp;

    assign w_i_req = bus.i_read;
    assign w_d_req = bus.d_read | bus.d_write;

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
        w_i_resp     = 1'b0;
        w_d_resp     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    if (rr_pick(r_last_grant) == GRANT_DATA) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
                end else if (w_i_req) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_next_state = I_BUSY;
                end else if (w_grant_d) begin
                    w_next_state = D_BUSY;
                end
            end

            I_BUSY: begin
                w_pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    w_i_resp     = 1'b1;
                    w_next_state = RELEASE;
                end
            end

            D_BUSY: begin
                w_pmem_read  = ~r_is_write;
                w_pmem_write = r_is_write;
                if (bus.pmem_resp) begin
                    w_d_resp     = 1'b1;
                    w_next_state = RELEASE;
                end
            end

            // One idle cycle lets the served cache drop its request before re-arbitration.
            RELEASE: w_next_state = IDLE;

            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_INST;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_addr       <= bus.i_address;
                r_is_write   <= 1'b0;
                r_last_grant <= GRANT_INST;
            end else if (w_grant_d) begin
                // d_read together with d_write is treated as a write.
                r_addr       <= bus.d_address;
                r_wdata      <= bus.d_wdata;
                r_is_write   <= bus.d_write;
                r_last_grant <= GRANT_DATA;
            end
        end
    end

    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata;
    assign bus.i_resp       = w_i_resp;
    assign bus.d_resp       = w_d_resp;
    assign bus.i_rdata      = bus.pmem_rdata;
    assign bus.d_rdata      = bus.pmem_rdata;

    a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
        !(bus.d_read && bus.d_write))
        else $warning("mem_arbiter: d_read and d_write asserted together, treated as write");

    a_resp_only_when_busy: assert property (@(posedge clk) disable iff (rst)
        bus.pmem_resp |-> (r_state == I_BUSY || r_state == D_BUSY))
        else $warning("mem_arbiter: stray pmem_resp outside a busy state ignored");

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed scenarios plus random two-requester traffic against
//                a cycle-count reference model of the arbiter.
//  Revision    : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input line_t obs, input line_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a pmem strobe, then checks its kind and address.
    task automatic wait_strobe(input string tag, input addr_t addr, input bit wr, output int n);
        n = 0;
        while (!(bus.pmem_read || bus.pmem_write) && n < 8) begin
            tick();
            settle();
            n++;
        end
        chk({tag, "_kind"}, line_t'({bus.pmem_write, bus.pmem_read}), line_t'(wr ? 2'b10 : 2'b01));
        chk({tag, "_addr"}, line_t'(bus.pmem_address), line_t'(addr));
    endtask

    // Holds the strobe for 'hold' extra cycles, then returns the response.
    task automatic finish_txn(input string tag, input bit to_d, input int hold, input addr_t addr, input line_t rdata);
        for (int k = 0; k < hold; k++) begin
            tick();
            settle();
            chk({tag, "_hold_strobe"}, line_t'(bus.pmem_read | bus.pmem_write), line_t'(1));
            chk({tag, "_hold_addr"}, line_t'(bus.pmem_address), line_t'(addr));
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rdata;
        settle();
        chk({tag, "_resp"}, line_t'({bus.d_resp, bus.i_resp}), line_t'(to_d ? 2'b10 : 2'b01));
        chk({tag, "_rdata"}, to_d ? bus.d_rdata : bus.i_rdata, rdata);
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Random-phase state: requesters, memory and reference model
    bit    ri, rd, rd_wr;
    addr_t ri_a, rd_a;
    line_t rd_wd;
    line_t mem [addr_t];
    int    mem_wait;
    bit    resp_now;
    line_t rdata_now;
    int    m_owner;     // 0 none, 1 icache, 2 dcache
    int    m_free_at;   // first cycle the arbiter may grant again
    bit    m_last_d;
    addr_t m_addr;
    bit    m_wr;
    line_t m_wd;
    int    i_done, d_done;

    initial begin
        int    n;
        line_t a5;
        line_t wd;
        a5 = {32{8'hA5}};
        wd = {8{32'h12345678}};

        // Reset state, including a pmem_resp that must be ignored
        rst = 1'b1;
        idle_inputs();
        tick();
        bus.pmem_resp = 1'b1;
        settle();
        chk("rst_strobes", line_t'({bus.pmem_write, bus.pmem_read}), line_t'(0));
        chk("rst_resps", line_t'({bus.d_resp, bus.i_resp}), line_t'(0));
        chk("rst_addr", line_t'(bus.pmem_address), line_t'(0));
        chk("rst_wdata", bus.pmem_wdata, line_t'(0));
        tick();
        bus.pmem_resp = 1'b0;
        rst = 1'b0;

        // I-only read
        bus.i_read = 1'b1;
        bus.i_address = 32'h60;
        settle();
        chk("t1_idle_no_strobe", line_t'(bus.pmem_read), line_t'(0));
        wait_strobe("t1", 32'h60, 1'b0, n);
        chk("t1_latency", line_t'(n), line_t'(1));
        finish_txn("t1", 1'b0, 2, 32'h60, a5);
        bus.i_read = 1'b0;
        settle();
        chk("t1_release_no_strobe", line_t'({bus.pmem_write, bus.pmem_read}), line_t'(0));
        chk("t1_release_no_resp", line_t'({bus.d_resp, bus.i_resp}), line_t'(0));
        tick();
        settle();
        chk("t1_idle_after", line_t'({bus.pmem_write, bus.pmem_read}), line_t'(0));

        // D write with address/data changing mid-transaction
        bus.d_write = 1'b1;
        bus.d_address = 32'h80;
        bus.d_wdata = wd;
        settle();
        wait_strobe("t2", 32'h80, 1'b1, n);
        chk("t2_latency", line_t'(n), line_t'(1));
        chk("t2_wdata", bus.pmem_wdata, wd);
        bus.d_address = 32'hFF;
        bus.d_wdata = ~wd;
        tick();
        settle();
        chk("t2_addr_latched", line_t'(bus.pmem_address), line_t'(32'h80));
        chk("t2_wdata_latched", bus.pmem_wdata, wd);
        finish_txn("t2", 1'b1, 1, 32'h80, '0);
        bus.d_write = 1'b0;
        settle();
        chk("t2_release", line_t'({bus.pmem_write, bus.pmem_read, bus.d_resp}), line_t'(0));

        // Conflict after reset: D first, then I
        do_reset();
        bus.i_read = 1'b1;
        bus.i_address = 32'h100;
        bus.d_read = 1'b1;
        bus.d_address = 32'h200;
        settle();
        wait_strobe("t3a", 32'h200, 1'b0, n);
        chk("t3a_latency", line_t'(n), line_t'(1));
        finish_txn("t3a", 1'b1, 0, 32'h200, rand_line());
        bus.d_read = 1'b0;
        settle();
        chk("t3_release", line_t'({bus.pmem_write, bus.pmem_read}), line_t'(0));
        wait_strobe("t3b", 32'h100, 1'b0, n);
        chk("t3b_gap", line_t'(n), line_t'(2));
        finish_txn("t3b", 1'b0, 1, 32'h100, rand_line());
        bus.i_read = 1'b0;
        bus.d_read = 1'b1;
        bus.d_address = 32'h220;
        settle();
        wait_strobe("t3c", 32'h220, 1'b0, n);
        finish_txn("t3c", 1'b1, 0, 32'h220, rand_line());
        // Second conflict after a D grant goes to I
        bus.i_read = 1'b1;
        bus.i_address = 32'h140;
        bus.d_address = 32'h240;
        settle();
        wait_strobe("t3d", 32'h140, 1'b0, n);
        finish_txn("t3d", 1'b0, 1, 32'h140, rand_line());
        bus.i_read = 1'b0;
        settle();
        wait_strobe("t3e", 32'h240, 1'b0, n);
        finish_txn("t3e", 1'b1, 0, 32'h240, rand_line());

        // D keeps re-requesting in RELEASE while I waits: I still wins next
        bus.d_address = 32'h300;
        settle();
        wait_strobe("t4a", 32'h300, 1'b0, n);
        bus.i_read = 1'b1;
        bus.i_address = 32'h180;
        finish_txn("t4a", 1'b1, 1, 32'h300, rand_line());
        bus.d_address = 32'h320;
        settle();
        wait_strobe("t4b", 32'h180, 1'b0, n);
        finish_txn("t4b", 1'b0, 0, 32'h180, rand_line());
        bus.i_read = 1'b0;
        settle();
        wait_strobe("t4c", 32'h320, 1'b0, n);
        finish_txn("t4c", 1'b1, 2, 32'h320, rand_line());
        bus.d_read = 1'b0;

        // Reset while I_BUSY; late response discarded; fresh request works
        bus.i_read = 1'b1;
        bus.i_address = 32'h1C0;
        settle();
        wait_strobe("t5a", 32'h1C0, 1'b0, n);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_read = 1'b0;
        settle();
        chk("t5_strobe_drop", line_t'({bus.pmem_write, bus.pmem_read}), line_t'(0));
        chk("t5_addr_cleared", line_t'(bus.pmem_address), line_t'(0));
        bus.pmem_resp = 1'b1;
        settle();
        chk("t5_late_resp_ignored", line_t'({bus.d_resp, bus.i_resp}), line_t'(0));
        tick();
        bus.pmem_resp = 1'b0;
        bus.i_read = 1'b1;
        bus.i_address = 32'h1E0;
        settle();
        wait_strobe("t5b", 32'h1E0, 1'b0, n);
        chk("t5b_latency", line_t'(n), line_t'(1));
        finish_txn("t5b", 1'b0, 1, 32'h1E0, rand_line());
        bus.i_read = 1'b0;
        tick();

        // Stray response in IDLE
        bus.pmem_resp = 1'b1;
        settle();
        chk("t6_stray_resps", line_t'({bus.d_resp, bus.i_resp}), line_t'(0));
        chk("t6_stray_strobes", line_t'({bus.pmem_write, bus.pmem_read}), line_t'(0));
        tick();
        bus.pmem_resp = 1'b0;

        // Random traffic against the cycle-count model
        do_reset();
        ri = 0; rd = 0; rd_wr = 0; ri_a = '0; rd_a = '0; rd_wd = '0;
        m_owner = 0; m_free_at = 0; m_last_d = 0; m_addr = '0; m_wr = 0; m_wd = '0;
        i_done = 0; d_done = 0;
        mem_wait = $urandom_range(3);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit pi, pd;
            if (!ri && $urandom_range(3) == 0) begin
                ri = 1;
                ri_a = addr_t'($urandom_range(7)) << 5;
            end
            if (!rd && $urandom_range(3) == 0) begin
                rd = 1;
                rd_wr = 1'($urandom_range(1));
                rd_a = addr_t'($urandom_range(7)) << 5;
                rd_wd = rand_line();
            end
            bus.i_read = ri;
            bus.i_address = ri_a;
            bus.d_read = rd && !rd_wr;
            bus.d_write = rd && rd_wr;
            bus.d_address = rd_a;
            bus.d_wdata = rd_wd;

            resp_now = 0;
            rdata_now = rand_line();
            if (bus.pmem_read || bus.pmem_write) begin
                if (mem_wait == 0) begin
                    resp_now = 1;
                    if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
                    else if (mem.exists(bus.pmem_address)) rdata_now = mem[bus.pmem_address];
                    else rdata_now = {8{bus.pmem_address}};
                    mem_wait = $urandom_range(3);
                end else begin
                    mem_wait--;
                end
            end
            bus.pmem_resp = resp_now;
            bus.pmem_rdata = rdata_now;
            settle();

            chk("r_pmem_read", line_t'(bus.pmem_read), line_t'(m_owner != 0 && !m_wr));
            chk("r_pmem_write", line_t'(bus.pmem_write), line_t'(m_owner != 0 && m_wr));
            if (m_owner != 0) chk("r_pmem_addr", line_t'(bus.pmem_address), line_t'(m_addr));
            if (m_owner == 2 && m_wr) chk("r_pmem_wdata", bus.pmem_wdata, m_wd);
            chk("r_i_resp", line_t'(bus.i_resp), line_t'(m_owner == 1 && resp_now));
            chk("r_d_resp", line_t'(bus.d_resp), line_t'(m_owner == 2 && resp_now));
            if (m_owner == 1 && resp_now) chk("r_i_rdata", bus.i_rdata, rdata_now);
            if (m_owner == 2 && resp_now && !m_wr) chk("r_d_rdata", bus.d_rdata, rdata_now);

            if (bus.i_resp) begin ri = 0; i_done++; end
            if (bus.d_resp) begin rd = 0; d_done++; end

            if (m_owner != 0) begin
                if (resp_now) begin
                    m_owner = 0;
                    m_free_at = cyc + 2;
                end
            end else if (cyc >= m_free_at) begin
                pi = bus.i_read;
                pd = bus.d_read | bus.d_write;
                if (pi && (!pd || m_last_d)) begin
                    m_owner = 1; m_addr = bus.i_address; m_wr = 0; m_last_d = 0;
                end else if (pd) begin
                    m_owner = 2; m_addr = bus.d_address; m_wr = bus.d_write;
                    m_wd = bus.d_wdata; m_last_d = 1;
                end
            end
            tick();
        end
        chk("r_i_served", line_t'(i_done > 10), line_t'(1));
        chk("r_d_served", line_t'(d_done > 10), line_t'(1));
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
